cmd_fetch_exec: RTL and testbench

- Instruction read/execute stage directly downstream of the PC register. Fetches the instruction at the current PC from an external synchronous instruction ROM and latches it into IR.
- Executes it on an 8-bit accumulator with Z/C flags.
- Drives the PC's 2-bit mode and load-data inputs to advance or jump, with a completion handshake against the PC value.
- Sits between the PC register and the board display/LED outputs.

---
 rtl/cmd_fetch_exec_pkg.sv | 48 ++++
 rtl/cmd_fetch_exec_if.sv | 23 ++
 rtl/cmd_fetch_exec_alu.sv | 68 ++++++
 rtl/cmd_fetch_exec.sv | 132 +++++++++++++
 tb/tb_cmd_fetch_exec.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_fetch_exec_pkg.sv
// Shared definitions for the fetch/execute stage: widths, instruction fields,
// opcodes, PC mode codes and the controller state encoding.
package cmd_pkg;

  localparam int DATA_W  = 8;
  localparam int OPC_W   = 4;
  localparam int INS_W   = OPC_W + DATA_W;

  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = DATA_W - 1;
  localparam int OPC_LSB = DATA_W;
  localparam int OPC_MSB = INS_W - 1;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h9;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hA;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] PCM_INC  = 2'b00;
  localparam logic [1:0] PCM_DEC  = 2'b01;
  localparam logic [1:0] PCM_HOLD = 2'b10;
  localparam logic [1:0] PCM_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_ADV   = 3'd4
  } state_t;

  function automatic logic [OPC_W-1:0] ins_opc(input logic [INS_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] ins_imm(input logic [INS_W-1:0] w);
    return w[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/cmd_fetch_exec_if.sv
// ROM read port and PC-register control bundle. The stage is the master:
// it drives the ROM address/strobe and the PC mode/load value.
interface cmd_fetch_exec_if;
  import cmd_pkg::*;

  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] rom_addr;
  logic              rom_en;
  logic [INS_W-1:0]  rom_data;
  logic [1:0]        pc_m;
  logic [DATA_W-1:0] pc_load;

  modport master (
    input  pc_in, rom_data,
    output rom_addr, rom_en, pc_m, pc_load
  );

  modport slave (
    output pc_in, rom_data,
    input  rom_addr, rom_en, pc_m, pc_load
  );

endinterface

// File: rtl/cmd_fetch_exec_alu.sv
// Combinational execute unit: next accumulator, next flags, branch decision
// and undefined-opcode detection for the instruction held in IR.
module cmd_alu
  import cmd_pkg::*;
(
  input  logic [OPC_W-1:0]  opc,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic              z_in,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z_nx,
  output logic              c_nx,
  output logic              jump_taken,
  output logic              illegal
);

  logic [DATA_W:0] wide;
  logic            upd_z;

  // Opcode decode; Z follows the result only for data-processing opcodes.
  always_comb begin
    result     = acc;
    c_nx       = c_in;
    jump_taken = 1'b0;
    illegal    = 1'b0;
    upd_z      = 1'b0;
    wide       = '0;
    case (opc)
      OP_LDI: begin
        result = imm;
        upd_z  = 1'b1;
      end
      OP_ADD: begin
        wide   = {1'b0, acc} + {1'b0, imm};
        result = wide[DATA_W-1:0];
        c_nx   = wide[DATA_W];
        upd_z  = 1'b1;
      end
      OP_SUB: begin
        // The wrapped ninth bit of the difference is the borrow.
        wide   = {1'b0, acc} - {1'b0, imm};
        result = wide[DATA_W-1:0];
        c_nx   = wide[DATA_W];
        upd_z  = 1'b1;
      end
      OP_AND: begin
        result = acc & imm;
        upd_z  = 1'b1;
      end
      OP_OR: begin
        result = acc | imm;
        upd_z  = 1'b1;
      end
      OP_XOR: begin
        result = acc ^ imm;
        upd_z  = 1'b1;
      end
      OP_JMP: jump_taken = 1'b1;
      OP_JZ:  jump_taken = z_in;
      OP_JC:  jump_taken = c_in;
      4'hB, 4'hC, 4'hD, 4'hE: illegal = 1'b1;
      default: ;
    endcase
    z_nx = upd_z ? (result == '0) : z_in;
  end

endmodule

// File: rtl/cmd_fetch_exec.sv
// Instruction fetch/execute stage. Reads the word at the current PC from a
// synchronous ROM, executes it on the accumulator and then steers the PC
// register (advance or jump) until the PC reports the new value.
//
// state | meaning
// IDLE  | waiting for run or a step rising edge; parked here once halted
// FETCH | ROM address/strobe presented (loaded from pc_in on entry)
// WAIT  | ROM latency; IR captured on the last cycle
// EXEC  | accumulator, flags, output register and status updated
// ADV   | PC told to increment or load; held until the PC value confirms
module cmd_fetch_exec
  import cmd_pkg::*;
#(
  parameter int ROM_LAT = 1
)(
  input  logic               clk,
  input  logic               pc_clr,
  input  logic               run,
  input  logic               step,
  cmd_fetch_exec_if.master   bus,
  output logic [INS_W-1:0]   ir,
  output logic [DATA_W-1:0]  acc,
  output logic               z_flag,
  output logic               c_flag,
  output logic [DATA_W-1:0]  out_reg,
  output logic               halted,
  output logic               illegal
);

  state_t            state, state_nx;
  logic              step_q;
  logic              step_rise;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] fa;
  logic              rom_en_q;
  logic              jmp_q;
  logic [DATA_W-1:0] pc_load_q;
  logic              adv_done;

  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_c, alu_jump, alu_illegal;

  assign opc       = ins_opc(ir);
  assign imm       = ins_imm(ir);
  assign step_rise = step & ~step_q;

  // A jump completes when the PC shows the target (so a jump to its own
  // address completes at once); an increment completes on any change,
  // which covers the FF->00 wrap.
  assign adv_done  = jmp_q ? (bus.pc_in == pc_load_q) : (bus.pc_in != fa);

  assign bus.rom_addr = fa;
  assign bus.rom_en   = rom_en_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_m     = (state == ST_ADV) ? (jmp_q ? PCM_LOAD : PCM_INC) : PCM_HOLD;

  cmd_alu u_alu (
    .opc        (opc),
    .acc        (acc),
    .imm        (imm),
    .z_in       (z_flag),
    .c_in       (c_flag),
    .result     (alu_result),
    .z_nx       (alu_z),
    .c_nx       (alu_c),
    .jump_taken (alu_jump),
    .illegal    (alu_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; step edges only matter in IDLE, so edges seen while
  // busy are dropped rather than queued.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (!halted && (run || step_rise)) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT:  if (wait_cnt == '0) state_nx = ST_EXEC;
      ST_EXEC:  state_nx = (opc == OP_HLT) ? ST_IDLE : ST_ADV;
      ST_ADV:   if (adv_done) state_nx = (run && !halted) ? ST_FETCH : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath registers: ROM request, IR capture and the execute commit.
  // The ROM address is registered on entry to FETCH so it is already
  // presented during the FETCH cycle; it doubles as the fetch address.
  always_ff @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      step_q    <= 1'b0;
      wait_cnt  <= '0;
      fa        <= '0;
      rom_en_q  <= 1'b0;
      jmp_q     <= 1'b0;
      pc_load_q <= '0;
      ir        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_reg   <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      step_q   <= step;
      rom_en_q <= (state_nx == ST_FETCH) || (state_nx == ST_WAIT);
      if (state_nx == ST_FETCH) fa <= bus.pc_in;
      if (state == ST_FETCH)
        wait_cnt <= 2'(ROM_LAT - 1);
      else if (state == ST_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 2'd1;
      if (state == ST_WAIT && wait_cnt == '0) ir <= bus.rom_data;
      if (state == ST_EXEC) begin
        acc    <= alu_result;
        z_flag <= alu_z;
        c_flag <= alu_c;
        jmp_q  <= alu_jump;
        if (alu_jump)        pc_load_q <= imm;
        if (opc == OP_OUT)   out_reg   <= acc;
        if (opc == OP_HLT)   halted    <= 1'b1;
        if (alu_illegal)     illegal   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_fetch_exec.sv
// Directed bench for cmd_fetch_exec with a behavioural ROM (latency 1) and a
// PC register model that performs one update per pc_m request.
module tb_cmd_fetch_exec;
  import cmd_pkg::*;

  logic clk = 1'b0;
  logic pc_clr, run, step;
  logic [INS_W-1:0]  ir;
  logic [DATA_W-1:0] acc, out_reg;
  logic z_flag, c_flag, halted, illegal;

  logic [INS_W-1:0]  rom [256];
  logic [INS_W-1:0]  rom_q;
  logic [DATA_W-1:0] pc;
  logic              pc_ack;
  logic              pc_go;
  int                fetch_cnt = 0;
  logic              en_d = 1'b0;
  int                tests = 0;
  int                failed = 0;
  int                base;

  cmd_fetch_exec_if bus ();

  cmd_fetch_exec #(.ROM_LAT(1)) dut (
    .clk     (clk),
    .pc_clr  (pc_clr),
    .run     (run),
    .step    (step),
    .bus     (bus.master),
    .ir      (ir),
    .acc     (acc),
    .z_flag  (z_flag),
    .c_flag  (c_flag),
    .out_reg (out_reg),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rom_en) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;
  assign bus.pc_in    = pc;

  always @(posedge clk or negedge pc_clr) begin
    if (!pc_clr) begin
      pc     <= '0;
      pc_ack <= 1'b0;
    end else if (bus.pc_m == PCM_HOLD) begin
      pc_ack <= 1'b0;
    end else if (pc_go && !pc_ack) begin
      pc_ack <= 1'b1;
      case (bus.pc_m)
        PCM_INC:  pc <= pc + 8'd1;
        PCM_DEC:  pc <= pc - 8'd1;
        default:  pc <= bus.pc_load;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.rom_en && !en_d) fetch_cnt <= fetch_cnt + 1;
    en_d <= bus.rom_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input int target, input string tag);
    int n = 0;
    while (fetch_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chk(tag, fetch_cnt, target);
  endtask

  task automatic wait_pcm(input logic [1:0] want, input string tag);
    int n = 0;
    while (bus.pc_m !== want && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, bus.pc_m}, {30'd0, want});
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h00] = 12'h105;
    rom[8'h01] = 12'h2FC;
    rom[8'h02] = 12'h103;
    rom[8'h03] = 12'h303;
    rom[8'h04] = 12'h840;
    rom[8'h40] = 12'h7FF;
    rom[8'hFF] = 12'h910;

    pc_clr = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    pc_go  = 1'b1;
    repeat (3) tick();
    chk("rst_rom_en",  {31'd0, bus.rom_en}, 32'd0);
    chk("rst_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
    chk("rst_pc_m",    {30'd0, bus.pc_m}, 32'd2);
    chk("rst_pc_load", {24'd0, bus.pc_load}, 32'd0);
    chk("rst_ir",      {20'd0, ir}, 32'd0);
    chk("rst_acc",     {24'd0, acc}, 32'd0);
    chk("rst_flags",   {30'd0, z_flag, c_flag}, 32'd0);
    chk("rst_out",     {24'd0, out_reg}, 32'd0);
    chk("rst_status",  {30'd0, halted, illegal}, 32'd0);

    // Abort the first instruction with a reset during WAIT.
    pc_clr = 1'b1;
    run    = 1'b1;
    wait_fetch(1, "first_fetch");
    tick();
    chk("wait_rom_en", {31'd0, bus.rom_en}, 32'd1);
    pc_clr = 1'b0;
    tick();
    chk("midrst_ir",     {20'd0, ir}, 32'd0);
    chk("midrst_acc",    {24'd0, acc}, 32'd0);
    chk("midrst_pc_m",   {30'd0, bus.pc_m}, 32'd2);
    chk("midrst_rom_en", {31'd0, bus.rom_en}, 32'd0);
    chk("midrst_addr",   {24'd0, bus.rom_addr}, 32'd0);

    // LDI 05; ADD FC -> acc 01 with carry.
    pc_clr = 1'b1;
    base = fetch_cnt;
    wait_fetch(base + 3, "fetch_addr2");
    chk("add_acc", {24'd0, acc}, 32'h01);
    chk("add_c",   {31'd0, c_flag}, 32'd1);
    chk("add_z",   {31'd0, z_flag}, 32'd0);

    // LDI 03; SUB 03 -> zero; JZ 40 held until the PC shows 40.
    wait_fetch(base + 5, "fetch_jz");
    pc_go = 1'b0;
    wait_pcm(PCM_LOAD, "jz_pc_m");
    chk("sub_acc",     {24'd0, acc}, 32'h00);
    chk("sub_z",       {31'd0, z_flag}, 32'd1);
    chk("sub_c",       {31'd0, c_flag}, 32'd0);
    chk("jz_pc_load",  {24'd0, bus.pc_load}, 32'h40);
    repeat (3) tick();
    chk("jz_hold",     {30'd0, bus.pc_m}, 32'd3);
    pc_go = 1'b1;
    wait_fetch(base + 6, "fetch_40");
    chk("fetch40_addr", {24'd0, bus.rom_addr}, 32'h40);
    chk("fetch40_pc_m", {30'd0, bus.pc_m}, 32'd2);

    // JMP FF, then JC 10 with c=0 increments across the FF->00 wrap.
    wait_fetch(base + 7, "fetch_ff");
    chk("fetchff_addr", {24'd0, bus.rom_addr}, 32'hFF);
    pc_go = 1'b0;
    wait_pcm(PCM_INC, "jc_pc_m");
    repeat (3) tick();
    chk("jc_hold", {30'd0, bus.pc_m}, 32'd0);
    run   = 1'b0;
    pc_go = 1'b1;
    wait_pcm(PCM_HOLD, "jc_done");
    chk("wrap_pc", {24'd0, pc}, 32'h00);
    repeat (5) tick();
    chk("run_drop_idle", fetch_cnt, base + 7);

    // Single-step: the step rising edge during EXEC is ignored.
    base = fetch_cnt;
    pulse_step();
    wait_fetch(base + 1, "step1_fetch");
    tick();
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (8) tick();
    chk("step_idle_cnt",  fetch_cnt, base + 1);
    chk("step_idle_pcm",  {30'd0, bus.pc_m}, 32'd2);
    chk("step_idle_en",   {31'd0, bus.rom_en}, 32'd0);
    chk("step1_acc",      {24'd0, acc}, 32'h05);
    pulse_step();
    repeat (10) tick();
    chk("step2_cnt", fetch_cnt, base + 2);
    chk("step2_acc", {24'd0, acc}, 32'h01);
    chk("step2_c",   {31'd0, c_flag}, 32'd1);

    // XOR FF; OUT; undefined opcode C; HLT.
    rom[8'h02] = 12'h6FF;
    rom[8'h03] = 12'hA00;
    rom[8'h04] = 12'hC00;
    rom[8'h05] = 12'hF00;
    run = 1'b1;
    begin
      int n = 0;
      while (halted !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("halted",     {31'd0, halted}, 32'd1);
    chk("illegal",    {31'd0, illegal}, 32'd1);
    chk("xor_acc",    {24'd0, acc}, 32'hFE);
    chk("out_reg",    {24'd0, out_reg}, 32'hFE);
    chk("hlt_pc",     {24'd0, pc}, 32'h05);
    chk("hlt_pc_m",   {30'd0, bus.pc_m}, 32'd2);
    base = fetch_cnt;
    pulse_step();
    repeat (10) tick();
    chk("halt_no_fetch", fetch_cnt, base);
    chk("halt_rom_en",   {31'd0, bus.rom_en}, 32'd0);
    chk("illegal_stick", {31'd0, illegal}, 32'd1);

    pc_clr = 1'b0;
    run    = 1'b0;
    tick();
    chk("rst2_status", {30'd0, halted, illegal}, 32'd0);
    chk("rst2_acc",    {24'd0, acc}, 32'd0);
    chk("rst2_out",    {24'd0, out_reg}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
